// File: rtl/rtc_pkg.sv
// rtc_pkg: definitions shared by the RTC bus write and read controllers.
//   - chip register addresses and the transfer-command address
//   - register index ordering (order of the wr_mask bits and of the snapshot array)
//   - bus sequencer state encoding
//   - entry_addr(): maps a register index to its chip address
package rtc_pkg;

    localparam logic [7:0] ADDR_SEG    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HORA   = 8'h23;
    localparam logic [7:0] ADDR_DIA    = 8'h24;
    localparam logic [7:0] ADDR_MES    = 8'h25;
    localparam logic [7:0] ADDR_ANO    = 8'h26;
    localparam logic [7:0] ADDR_CRSEG  = 8'h41;
    localparam logic [7:0] ADDR_CRMIN  = 8'h42;
    localparam logic [7:0] ADDR_CRHORA = 8'h43;
    localparam logic [7:0] ADDR_XFER   = 8'hF1;

    localparam int unsigned NUM_REGS    = 9;
    localparam int unsigned NUM_ENTRIES = 10;

    localparam int unsigned IDX_SEG    = 0;
    localparam int unsigned IDX_MIN    = 1;
    localparam int unsigned IDX_HORA   = 2;
    localparam int unsigned IDX_DIA    = 3;
    localparam int unsigned IDX_MES    = 4;
    localparam int unsigned IDX_ANO    = 5;
    localparam int unsigned IDX_CRSEG  = 6;
    localparam int unsigned IDX_CRMIN  = 7;
    localparam int unsigned IDX_CRHORA = 8;
    localparam int unsigned IDX_XFER   = 9;

    typedef enum logic [2:0] {
        StIdle,
        StNext,
        StAddrLo,
        StAddrHi,
        StDataLo,
        StDataHi,
        StDone
    } state_e;

    function automatic logic [7:0] entry_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = ADDR_SEG;
            4'd1:    a = ADDR_MIN;
            4'd2:    a = ADDR_HORA;
            4'd3:    a = ADDR_DIA;
            4'd4:    a = ADDR_MES;
            4'd5:    a = ADDR_ANO;
            4'd6:    a = ADDR_CRSEG;
            4'd7:    a = ADDR_CRMIN;
            4'd8:    a = ADDR_CRHORA;
            default: a = ADDR_XFER;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_write_ctrl_if.sv
// rtc_write_ctrl_if: register-bank inputs and RTC pad outputs of the write controller.
//   master: the controller (reads start/wr_mask/values, drives the pad side)
//   slave:  the environment (drives start/wr_mask/values, observes the pad side)
interface rtc_write_ctrl_if;
    logic       start;
    logic [9:0] wr_mask;
    logic [7:0] hora, min, seg, dia, mes, ano, crhora, crmin, crseg;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n, wr_n, rd_n;
    logic       ad_n;
    logic       busy;
    logic       done;

    modport master (
        input  start, wr_mask, hora, min, seg, dia, mes, ano, crhora, crmin, crseg,
        output ad_out, ad_oe, cs_n, wr_n, rd_n, ad_n, busy, done
    );

    modport slave (
        output start, wr_mask, hora, min, seg, dia, mes, ano, crhora, crmin, crseg,
        input  ad_out, ad_oe, cs_n, wr_n, rd_n, ad_n, busy, done
    );
endinterface

// File: rtl/rtc_bus_phase.sv
// rtc_bus_phase: strobe phase timer.
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : reload the counter (asserted on every sequencer state change)
//   low_i      : with load_i, select the strobe-low length instead of the strobe-high length
//   last_o     : current cycle is the final cycle of the phase
module rtc_bus_phase #(
    parameter int unsigned T_LOW  = 4,
    parameter int unsigned T_HIGH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic low_i,
    output logic last_o
);
    localparam int unsigned TMax = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
    localparam int unsigned CntW = $clog2(TMax) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter holds "cycles remaining after this one"; it saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = low_i ? CntW'(T_LOW - 1) : CntW'(T_HIGH - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/rtc_write_ctrl.sv
// rtc_write_ctrl: writes a snapshot of the time/date/timer registers to the external RTC
// chip over its multiplexed address/data bus, one address strobe and one data strobe per
// selected register, optionally followed by the transfer command.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : start/wr_mask/register values in; ad_out, ad_oe, cs_n, wr_n, rd_n, ad_n,
//                busy, done out (all outputs registered)
module rtc_write_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned T_LOW     = 4,
    parameter int unsigned T_HIGH    = 4,
    parameter logic [7:0]  XFER_DATA = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    rtc_write_ctrl_if.master bus
);
    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [9:0] mask_q, mask_d;
    logic [7:0] snap_q [NUM_REGS];
    logic [7:0] snap_d [NUM_REGS];

    logic       cs_n_q, cs_n_d, wr_n_q, wr_n_d, ad_n_q, ad_n_d;
    logic       ad_oe_q, ad_oe_d, busy_q, busy_d, done_q, done_d;
    logic [7:0] ad_out_q, ad_out_d;

    logic phase_last;
    logic phase_load;
    logic phase_low;

    rtc_bus_phase #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH)
    ) u_phase (
        .clk    (clk),
        .reset  (reset),
        .load_i (phase_load),
        .low_i  (phase_low),
        .last_o (phase_last)
    );

    assign phase_load = (state_d != state_q);
    assign phase_low  = (state_d == StAddrLo) || (state_d == StDataLo);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        snap_d  = snap_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    snap_d[IDX_SEG]    = bus.seg;
                    snap_d[IDX_MIN]    = bus.min;
                    snap_d[IDX_HORA]   = bus.hora;
                    snap_d[IDX_DIA]    = bus.dia;
                    snap_d[IDX_MES]    = bus.mes;
                    snap_d[IDX_ANO]    = bus.ano;
                    snap_d[IDX_CRSEG]  = bus.crseg;
                    snap_d[IDX_CRMIN]  = bus.crmin;
                    snap_d[IDX_CRHORA] = bus.crhora;
                    mask_d             = bus.wr_mask;
                    idx_d              = '0;
                    state_d            = StNext;
                end
            end
            StNext: begin
                if (idx_q == 4'(NUM_ENTRIES)) begin
                    state_d = StDone;
                end else if (mask_q[idx_q]) begin
                    state_d = StAddrLo;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StAddrLo: if (phase_last) state_d = StAddrHi;
            StAddrHi: if (phase_last) state_d = StDataLo;
            StDataLo: if (phase_last) state_d = StDataHi;
            StDataHi: begin
                if (phase_last) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StNext;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Pad outputs are registered from the next state so they line up with it.
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_n_d   = ad_n_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = (state_d != StIdle);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        case (state_d)
            StIdle: begin
                ad_out_d = '0;
                ad_n_d   = 1'b1;
            end
            StAddrLo: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_out_d = entry_addr(idx_d);
            end
            StDataLo: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_n_d   = 1'b1;
                ad_out_d = (idx_d == 4'(IDX_XFER)) ? XFER_DATA : snap_q[idx_d];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            mask_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            snap_q   <= snap_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            ad_n_q   <= ad_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cs_n   = cs_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.rd_n   = 1'b1;
    assign bus.ad_n   = ad_n_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
